risc_mgmt_mem_port: RTL

//  Memory-request sequencer between the RISC-MGMT extension memory signals
//  (req_mem/mem_ren/mem_wen/mem_addr/mem_store) and the core data-bus port.

---
 rtl/risc_mgmt_mem_port.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/risc_mgmt_mem_port.sv
// risc_mgmt_mem_port
// Sequences single-word memory requests from the RISC-MGMT extension onto the
// core data-bus port. A request is registered in IDLE, the bus strobe is held
// through ACCESS until the bus completes (or the access times out), and DONE
// returns the read data with rm_mem_busy low for exactly one cycle.
// Malformed requests and bus timeouts are reported to the hazard unit as
// one-cycle pulses.

module risc_mgmt_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rm_req_mem,
    input  logic        rm_mem_ren,
    input  logic        rm_mem_wen,
    input  logic [31:0] rm_mem_addr,
    input  logic [31:0] rm_mem_store,
    output logic [31:0] rm_mem_load,
    output logic        rm_mem_busy,
    input  logic        flush,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [3:0]  bus_byte_en,
    input  logic        bus_busy,
    input  logic [31:0] bus_rdata,
    output logic        misaligned,
    output logic        illegal,
    output logic        timeout
);

    // Counter wide enough to hold TIMEOUT_CYCLES-1; it saturates there.
    localparam int unsigned       CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             dir_wr;       // latched direction: 1 = write, 0 = read
    logic             flush_seen;   // flush arrived during a write ACCESS
    logic [CNT_W-1:0] count;        // ACCESS cycles elapsed

    logic             dir_ok;
    logic             addr_ok;
    logic             valid_req;

    logic             accept;
    logic             bus_done;
    logic             abort;

    assign dir_ok    = rm_mem_ren ^ rm_mem_wen;
    assign addr_ok   = (rm_mem_addr[1:0] == 2'b00);
    assign valid_req = rm_req_mem & dir_ok & addr_ok;

    // Next-state decode and per-cycle events for the request sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nxt = state;
        accept    = 1'b0;
        bus_done  = 1'b0;
        abort     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (valid_req && !flush) begin
                    accept    = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (!dir_wr && flush) begin
                    // A read can be abandoned safely: drop the strobe, keep load.
                    state_nxt = ST_IDLE;
                end else if (!bus_busy) begin
                    // Bus completion takes priority over a same-cycle timeout.
                    bus_done  = 1'b1;
                    // A write that saw a flush still completes but skips DONE.
                    state_nxt = (dir_wr && (flush || flush_seen)) ? ST_IDLE : ST_DONE;
                end else if (count == CNT_MAX) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus strobes and the busy handshake are decoded from the registered state.
    always_comb begin
        bus_ren     = (state == ST_ACCESS) && !dir_wr;
        bus_wen     = (state == ST_ACCESS) &&  dir_wr;
        bus_byte_en = (state == ST_ACCESS) ? 4'hF : 4'h0;
        rm_mem_busy = (state == ST_ACCESS) || ((state == ST_IDLE) && valid_req);
    end

    // State register, request latches, cycle counter and status pulses.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            state       <= ST_IDLE;
            bus_addr    <= 32'h0;
            bus_wdata   <= 32'h0;
            dir_wr      <= 1'b0;
            flush_seen  <= 1'b0;
            count       <= '0;
            rm_mem_load <= 32'h0;
            misaligned  <= 1'b0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state <= state_nxt;

            // Malformed requests are only examined while waiting in IDLE;
            // a direction error masks an alignment error.
            illegal    <= (state == ST_IDLE) && rm_req_mem && !dir_ok;
            misaligned <= (state == ST_IDLE) && rm_req_mem && dir_ok && !addr_ok;
            timeout    <= abort;

            if (accept) begin
                bus_addr   <= rm_mem_addr;
                bus_wdata  <= rm_mem_store;
                dir_wr     <= rm_mem_wen;
                flush_seen <= 1'b0;
                count      <= '0;
            end else if (state == ST_ACCESS) begin
                if (count != CNT_MAX) begin
                    count <= count + CNT_ONE;
                end
                if (flush) begin
                    flush_seen <= 1'b1;
                end
            end

            if (bus_done && !dir_wr) begin
                rm_mem_load <= bus_rdata;
            end else if (abort) begin
                rm_mem_load <= 32'h0;
            end
        end
    end

endmodule
